// File: rtl/fir16_sample_feeder_if.sv
// Sample stream and coefficient write port of the FIR front end.
// The master drives samples and coefficient writes; the feeder, as slave, answers with in_ready.
interface fir16_sample_feeder_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [DATA_W-1:0] in_sample;
    logic              in_ready;
    logic              flush;
    logic              coeff_we;
    logic [3:0]        coeff_addr;
    logic [DATA_W-1:0] coeff_data;

    modport master (
        output in_valid, in_sample, flush, coeff_we, coeff_addr, coeff_data,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_sample, flush, coeff_we, coeff_addr, coeff_data,
        output in_ready
    );
endinterface

// File: rtl/fir16_sample_feeder.sv
// Feeds the 16-tap FIR MAC: sample delay line, coefficient registers, and the mac_valid strobe.
// The strobe is delayed to line up with the MAC pipeline. A flush drains the filter tail with zeros.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   ST_FILL  | delay line holds fewer than TAPS real samples
//   ST_RUN   | window full, every accept produces a MAC result
//   ST_FLUSH | shifting TAPS zeros in, input stalled
module fir16_sample_feeder #(
    parameter int DATA_W  = 16,
    parameter int TAPS    = 16,
    parameter int MAC_LAT = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    fir16_sample_feeder_if.slave     bus,
    output logic [DATA_W*TAPS-1:0]   samples_flat,
    output logic [DATA_W-1:0]        coeff0,
    output logic [DATA_W-1:0]        coeff1,
    output logic [DATA_W-1:0]        coeff2,
    output logic [DATA_W-1:0]        coeff3,
    output logic [DATA_W-1:0]        coeff4,
    output logic [DATA_W-1:0]        coeff5,
    output logic [DATA_W-1:0]        coeff6,
    output logic [DATA_W-1:0]        coeff7,
    output logic [DATA_W-1:0]        coeff8,
    output logic [DATA_W-1:0]        coeff9,
    output logic [DATA_W-1:0]        coeff10,
    output logic [DATA_W-1:0]        coeff11,
    output logic [DATA_W-1:0]        coeff12,
    output logic [DATA_W-1:0]        coeff13,
    output logic [DATA_W-1:0]        coeff14,
    output logic [DATA_W-1:0]        coeff15,
    output logic                     window_full,
    output logic                     mac_valid,
    output logic                     busy_flush
);

    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam int             WIN_W    = DATA_W * TAPS;
    localparam int             CNT_W    = $clog2(TAPS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] FLUSH_LD = CNT_W'(TAPS - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  fill_cnt;
    logic [CNT_W-1:0]  flush_cnt;
    logic              flush_from_run;
    logic [WIN_W-1:0]  window;
    logic [MAC_LAT:0]  strobe_pipe;
    logic [DATA_W-1:0] coeff_q [TAPS];

    logic              accept;
    logic              flush_req;
    logic              flush_done;
    logic [CNT_W-1:0]  cnt_inc;
    logic              strobe;

    assign bus.in_ready = (state != ST_FLUSH);
    assign accept       = bus.in_valid && bus.in_ready;
    assign flush_req    = bus.flush &&
                          (((state == ST_FILL) && (fill_cnt != '0)) || (state == ST_RUN));
    assign flush_done   = (state == ST_FLUSH) && (flush_cnt == '0);
    assign cnt_inc      = (fill_cnt == CNT_FULL) ? CNT_FULL : fill_cnt + CNT_W'(1);

    // One strobe per window that the MAC should turn into a valid output.
    assign strobe = (accept && (cnt_inc == CNT_FULL)) ||
                    ((state == ST_FLUSH) && flush_from_run);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_FILL;
            fill_cnt       <= '0;
            flush_cnt      <= '0;
            flush_from_run <= 1'b0;
            window         <= '0;
        end else begin
            case (state)
                ST_FILL, ST_RUN: begin
                    if (accept) begin
                        window   <= {window[WIN_W-DATA_W-1:0], bus.in_sample};
                        fill_cnt <= cnt_inc;
                    end
                    if (flush_req) begin
                        state          <= ST_FLUSH;
                        flush_from_run <= (state == ST_RUN);
                        flush_cnt      <= FLUSH_LD;
                    end else if (accept && (cnt_inc == CNT_FULL)) begin
                        state <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    window <= {window[WIN_W-DATA_W-1:0], {DATA_W{1'b0}}};
                    if (flush_done) begin
                        state          <= ST_FILL;
                        fill_cnt       <= '0;
                        flush_from_run <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_FILL;
                end
            endcase
        end
    end

    // Stage 0 registers alongside the window; the last stage lines up with y_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_pipe <= '0;
        end else begin
            strobe_pipe <= {strobe_pipe[MAC_LAT-1:0], strobe};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                coeff_q[i] <= '0;
            end
        end else if (bus.coeff_we) begin
            coeff_q[bus.coeff_addr] <= bus.coeff_data;
        end
    end

    assign samples_flat = window;
    assign window_full  = (state == ST_RUN) || ((state == ST_FLUSH) && flush_from_run);
    assign busy_flush   = (state == ST_FLUSH);
    assign mac_valid    = strobe_pipe[MAC_LAT];

    assign coeff0  = coeff_q[0];
    assign coeff1  = coeff_q[1];
    assign coeff2  = coeff_q[2];
    assign coeff3  = coeff_q[3];
    assign coeff4  = coeff_q[4];
    assign coeff5  = coeff_q[5];
    assign coeff6  = coeff_q[6];
    assign coeff7  = coeff_q[7];
    assign coeff8  = coeff_q[8];
    assign coeff9  = coeff_q[9];
    assign coeff10 = coeff_q[10];
    assign coeff11 = coeff_q[11];
    assign coeff12 = coeff_q[12];
    assign coeff13 = coeff_q[13];
    assign coeff14 = coeff_q[14];
    assign coeff15 = coeff_q[15];

endmodule

// File: tb/tb_fir16_sample_feeder.sv
// Directed bench for fir16_sample_feeder: fill, run, flush variants, coefficient writes, async reset.
module tb_fir16_sample_feeder;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [255:0] samples_flat;
    logic [15:0]  coeff0, coeff1, coeff2, coeff3, coeff4, coeff5, coeff6, coeff7;
    logic [15:0]  coeff8, coeff9, coeff10, coeff11, coeff12, coeff13, coeff14, coeff15;
    logic         window_full;
    logic         mac_valid;
    logic         busy_flush;

    fir16_sample_feeder_if bus ();

    fir16_sample_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .samples_flat (samples_flat),
        .coeff0       (coeff0),
        .coeff1       (coeff1),
        .coeff2       (coeff2),
        .coeff3       (coeff3),
        .coeff4       (coeff4),
        .coeff5       (coeff5),
        .coeff6       (coeff6),
        .coeff7       (coeff7),
        .coeff8       (coeff8),
        .coeff9       (coeff9),
        .coeff10      (coeff10),
        .coeff11      (coeff11),
        .coeff12      (coeff12),
        .coeff13      (coeff13),
        .coeff14      (coeff14),
        .coeff15      (coeff15),
        .window_full  (window_full),
        .mac_valid    (mac_valid),
        .busy_flush   (busy_flush)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           mac_cnt  = 0;
    int           m0;
    int           errs;
    logic [255:0] exp_win;

    always @(negedge clk) begin
        if (mac_valid === 1'b1) mac_cnt <= mac_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_checks++;
        if (got !== want)
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v);
        bus.in_valid  = 1'b1;
        bus.in_sample = v;
        tick();
        bus.in_valid  = 1'b0;
        exp_win = {exp_win[239:0], v};
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_sample  = '0;
        bus.flush      = 1'b0;
        bus.coeff_we   = 1'b0;
        bus.coeff_addr = '0;
        bus.coeff_data = '0;
        exp_win        = '0;

        #2 reset = 1'b1;
        #1;
        check_val("rst_window", samples_flat, '0);
        check_val("rst_full", window_full, 0);
        check_val("rst_mac", mac_valid, 0);
        check_val("rst_busy", busy_flush, 0);
        check_val("rst_coeff15", coeff15, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        check_val("rst_ready", bus.in_ready, 1);

        for (int i = 0; i < 16; i++) begin
            bus.coeff_we   = 1'b1;
            bus.coeff_addr = 4'(i);
            bus.coeff_data = 16'h7FFF;
            tick();
        end
        bus.coeff_we = 1'b0;
        check_val("coeff0_load", coeff0, 16'h7FFF);
        check_val("coeff15_load", coeff15, 16'h7FFF);
        check_val("coeff_no_shift", samples_flat, '0);

        // fill with 1..16
        m0   = mac_cnt;
        errs = 0;
        for (int i = 1; i <= 16; i++) begin
            send(16'(i));
            if (i < 16 && (bus.in_ready !== 1'b1 || window_full !== 1'b0 || mac_valid !== 1'b0))
                errs++;
        end
        check_val("fill_phase_errs", errs, 0);
        check_val("fill_full", window_full, 1);
        check_val("fill_window", samples_flat, exp_win);
        check_val("fill_slot0", samples_flat[15:0], 16'd16);
        check_val("fill_slot15", samples_flat[255:240], 16'd1);
        check_val("fill_mac_k0", mac_valid, 0);
        tick();
        check_val("fill_mac_k1", mac_valid, 0);
        tick();
        check_val("fill_mac_k2", mac_valid, 1);
        check_val("fill_mac_window", samples_flat, exp_win);
        tick();
        check_val("fill_mac_k3", mac_valid, 0);
        check_val("fill_mac_count", mac_cnt - m0, 1);

        // RUN with in_valid 1,0,1
        send(16'd17);
        check_val("run_a_window", samples_flat, exp_win);
        check_val("run_a_mac", mac_valid, 0);
        tick();
        check_val("run_idle_window", samples_flat, exp_win);
        check_val("run_b_mac", mac_valid, 0);
        send(16'd18);
        check_val("run_c_window", samples_flat, exp_win);
        check_val("run_c_mac", mac_valid, 1);
        tick();
        check_val("run_idle_mac", mac_valid, 0);
        tick();
        check_val("run_c2_mac", mac_valid, 1);
        tick();

        // flush from RUN
        m0 = mac_cnt;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        errs = 0;
        for (int j = 0; j < 16; j++) begin
            if (busy_flush !== 1'b1 || bus.in_ready !== 1'b0 || window_full !== 1'b1) errs++;
            if (samples_flat !== exp_win) errs++;
            tick();
            exp_win = {exp_win[239:0], 16'h0000};
        end
        check_val("flush_run_errs", errs, 0);
        check_val("flush_run_busy_end", busy_flush, 0);
        check_val("flush_run_ready_end", bus.in_ready, 1);
        check_val("flush_run_full_end", window_full, 0);
        check_val("flush_run_window", samples_flat, '0);
        repeat (3) tick();
        check_val("flush_run_macs", mac_cnt - m0, 16);

        // flush coinciding with an accept, from FILL
        exp_win = '0;
        send(16'h0011);
        send(16'h0022);
        send(16'h0033);
        send(16'h0044);
        m0 = mac_cnt;
        bus.flush     = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_sample = 16'h1234;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check_val("flush_acc_slot0", samples_flat[15:0], 16'h1234);
        check_val("flush_acc_slot1", samples_flat[31:16], 16'h0044);
        check_val("flush_acc_busy", busy_flush, 1);
        tick();
        check_val("flush_acc_zero0", samples_flat[15:0], 16'h0000);
        check_val("flush_acc_slot1b", samples_flat[31:16], 16'h1234);
        repeat (15) tick();
        check_val("flush_acc_busy_end", busy_flush, 0);
        check_val("flush_acc_window", samples_flat, '0);
        repeat (2) tick();
        check_val("flush_acc_macs", mac_cnt - m0, 0);

        // flush at count 0 is ignored
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check_val("flush_empty_ignored", busy_flush, 0);

        // flush from FILL with count 5
        exp_win = '0;
        for (int i = 1; i <= 5; i++) send(16'(16'h0100 + i));
        m0 = mac_cnt;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        errs = 0;
        for (int j = 0; j < 16; j++) begin
            if (busy_flush !== 1'b1 || window_full !== 1'b0 || mac_valid !== 1'b0) errs++;
            tick();
        end
        check_val("flush_fill_errs", errs, 0);
        check_val("flush_fill_busy_end", busy_flush, 0);
        check_val("flush_fill_window", samples_flat, '0);
        repeat (2) tick();
        check_val("flush_fill_macs", mac_cnt - m0, 0);

        // coefficient write together with an accept; refill confirms count restarted at 0
        exp_win        = '0;
        bus.coeff_we   = 1'b1;
        bus.coeff_addr = 4'd3;
        bus.coeff_data = 16'h8000;
        send(16'h0AAA);
        bus.coeff_we   = 1'b0;
        check_val("cw_coeff3", coeff3, 16'h8000);
        check_val("cw_coeff2", coeff2, 16'h7FFF);
        check_val("cw_slot0", samples_flat[15:0], 16'h0AAA);
        for (int i = 2; i <= 15; i++) send(16'(16'h0200 + i));
        check_val("refill_15_full", window_full, 0);
        send(16'h0210);
        check_val("refill_16_full", window_full, 1);
        check_val("refill_window", samples_flat, exp_win);
        repeat (3) tick();

        // async reset in the middle of a flush from RUN
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        repeat (6) tick();
        @(posedge clk);
        #3 reset = 1'b1;
        m0 = mac_cnt;
        #1;
        check_val("arst_window", samples_flat, '0);
        check_val("arst_full", window_full, 0);
        check_val("arst_mac", mac_valid, 0);
        check_val("arst_busy", busy_flush, 0);
        check_val("arst_coeff3", coeff3, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) tick();
        check_val("arst_no_mac", mac_cnt - m0, 0);
        check_val("arst_ready", bus.in_ready, 1);
        check_val("arst_busy_after", busy_flush, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
